clock_ctrl: RTL and testbench

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_ctrl.sv | 126 ++++++++++++
 tb/tb_clock_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// Clock-setting controller: debounced mode/inc/clr buttons,
// 1 Hz divider, set-mode FSM and field blink.
module clock_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_clr,
  output logic       tick_1hz,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_sec,
  output logic       clr_time,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int DW = $clog2(CLK_HZ);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] SET_HOUR = 2'b01;
  localparam logic [1:0] SET_MIN  = 2'b10;
  localparam logic [1:0] SET_SEC  = 2'b11;

  logic [2:0]    btn;
  logic [2:0]    s1, s2;
  logic [2:0]    lvl, lvl_q;
  logic [2:0]    press;
  logic [CW-1:0] cnt [3];

  assign btn = {btn_clr, btn_inc, btn_mode};

  // bit 0 mode, bit 1 inc, bit 2 clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      lvl   <= '0;
      lvl_q <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      lvl_q <= lvl;
      press <= lvl & ~lvl_q;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
          cnt[i] <= '0;
          lvl[i] <= s2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  logic [1:0]    mode_q, mode_nxt;
  logic [DW-1:0] div, div_nxt;
  logic          reload_q, reload_nxt;
  logic          inc_vld, tick_nxt;

  assign inc_vld = press[1] & ~press[2];

  always_comb begin
    mode_nxt   = mode_q;
    reload_nxt = 1'b0;
    unique case (1'b1)
      press[2]: begin
        mode_nxt   = RUN;
        reload_nxt = 1'b1;
      end
      press[0] & ~press[2]: begin
        mode_nxt   = mode_q + 2'd1;
        reload_nxt = (mode_q == SET_SEC);
      end
      default: ;
    endcase
  end

  // Divider restarts the cycle after re-entering RUN, so the
  // first tick lands a full second after the mode change.
  always_comb begin
    if (reload_q)
      div_nxt = '0;
    else if (div == DW'(CLK_HZ - 1))
      div_nxt = '0;
    else
      div_nxt = div + DW'(1);
  end

  assign tick_nxt = (div_nxt == DW'(CLK_HZ - 1))
                  & (mode_nxt == RUN) & ~reload_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= RUN;
      div      <= '0;
      reload_q <= 1'b0;
      tick_1hz <= 1'b0;
      inc_hour <= 1'b0;
      inc_min  <= 1'b0;
      inc_sec  <= 1'b0;
      clr_time <= 1'b0;
    end else begin
      mode_q   <= mode_nxt;
      div      <= div_nxt;
      reload_q <= reload_nxt;
      tick_1hz <= tick_nxt;
      clr_time <= press[2];
      inc_hour <= inc_vld & (mode_q == SET_HOUR);
      inc_min  <= inc_vld & (mode_q == SET_MIN);
      inc_sec  <= inc_vld & (mode_q == SET_SEC);
    end
  end

  assign mode  = mode_q;
  assign blink = (div < DW'(CLK_HZ / 2));

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: directed scenarios plus random buttons,
// checked each cycle against a window-based behavioural model.
module tb_clock_ctrl;

  localparam int HZ  = 10;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_clr = 1'b0;
  logic       tick_1hz, inc_hour, inc_min, inc_sec, clr_time;
  logic [1:0] mode;
  logic       blink;

  clock_ctrl #(.CLK_HZ(HZ), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_clr(btn_clr),
    .tick_1hz(tick_1hz), .inc_hour(inc_hour),
    .inc_min(inc_min), .inc_sec(inc_sec),
    .clr_time(clr_time), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: cycle index since reset, raw samples since reset,
  // debounced levels, visible presses, second anchor
  int         t;
  logic [2:0] hist[$];
  logic [2:0] lvl_m, pv, rise_d;
  logic [1:0] mode_m;
  int         anchor;
  logic e_tick, e_ih, e_im, e_is, e_clr, e_blink;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d: got %0d expected %0d",
             tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    hist.delete();
    lvl_m = '0;
    pv = '0;
    rise_d = '0;
    mode_m = 2'd0;
    anchor = 0;
    e_tick = 0; e_ih = 0; e_im = 0; e_is = 0; e_clr = 0;
    e_blink = 1;
  endtask

  function automatic logic sample(int s, int b);
    logic [2:0] v;
    if (s < 1) return 1'b0;
    v = hist[s-1];
    return v[b];
  endfunction

  task automatic model_edge();
    logic ev;
    bit   diff;
    int   ph;
    t++;
    hist.push_back({btn_clr, btn_inc, btn_mode});
    e_ih = 0; e_im = 0; e_is = 0; e_clr = 0;
    ev = 0;
    if (pv[2]) begin
      e_clr = 1;
      mode_m = 2'd0;
      ev = 1;
    end else begin
      if (pv[1]) begin
        e_ih = (mode_m == 2'd1);
        e_im = (mode_m == 2'd2);
        e_is = (mode_m == 2'd3);
      end
      if (pv[0]) begin
        if (mode_m == 2'd3) ev = 1;
        mode_m = mode_m + 2'd1;
      end
    end
    ph = (t - anchor) % HZ;
    e_blink = (ph < HZ / 2);
    e_tick = (mode_m == 2'd0) && (ph == HZ - 1) && !ev;
    if (ev) anchor = t + 1;
    pv = rise_d;
    rise_d = '0;
    // level follows input once the synced copy disagreed DEB times
    for (int b = 0; b < 3; b++) begin
      diff = 1;
      for (int s = t - 2; s >= t - 1 - DEB; s--)
        if (sample(s, b) == lvl_m[b]) diff = 0;
      if (diff) begin
        if (!lvl_m[b]) rise_d[b] = 1;
        lvl_m[b] = ~lvl_m[b];
      end
    end
  endtask

  task automatic check_all();
    chk("mode", {2'b0, mode}, {2'b0, mode_m});
    chk("tick", {3'b0, tick_1hz}, {3'b0, e_tick});
    chk("inc_hour", {3'b0, inc_hour}, {3'b0, e_ih});
    chk("inc_min", {3'b0, inc_min}, {3'b0, e_im});
    chk("inc_sec", {3'b0, inc_sec}, {3'b0, e_is});
    chk("clr_time", {3'b0, clr_time}, {3'b0, e_clr});
    chk("blink", {3'b0, blink}, {3'b0, e_blink});
    chk("excl", {2'b0, 2'(inc_hour + inc_min + inc_sec + clr_time)} > 4'd1 ? 4'd1 : 4'd0, 4'd0);
    chk("tick_clr", {3'b0, tick_1hz & clr_time}, 4'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();
  endtask

  task automatic hold(input logic [2:0] b, input int n);
    {btn_clr, btn_inc, btn_mode} = b;
    repeat (n) step();
    {btn_clr, btn_inc, btn_mode} = 3'b000;
  endtask

  int ticks[$];
  int cnt_p, cnt_t, c_clr, c_tick;

  initial begin
    model_reset();
    #1 check_all();
    #12;
    @(negedge clk);
    rst_n = 1'b1;

    // free-running ticks from reset
    ticks.delete();
    repeat (35) begin
      step();
      if (tick_1hz) ticks.push_back(t);
    end
    chk("tick_count", 4'(ticks.size()), 4'd3);
    if (ticks.size() == 3) begin
      chk("tick0", 4'(ticks[0]), 4'd9);
      chk("tick1", 4'(ticks[1] - 10), 4'd9);
      chk("tick2", 4'(ticks[2] - 20), 4'd9);
    end

    // mode press held 8 cycles lands on cycle 8
    {btn_clr, btn_inc, btn_mode} = 3'b001;
    repeat (7) step();
    chk("mode_c7", {2'b0, mode}, 4'd0);
    step();
    btn_mode = 1'b0;
    chk("mode_c8", {2'b0, mode}, 4'd1);
    repeat (8) step();
    cnt_p = 0; cnt_t = 0;
    {btn_clr, btn_inc, btn_mode} = 3'b010;
    repeat (6) begin
      step();
      cnt_p += int'(inc_hour); cnt_t += int'(tick_1hz);
    end
    btn_inc = 1'b0;
    repeat (12) begin
      step();
      cnt_p += int'(inc_hour); cnt_t += int'(tick_1hz);
    end
    chk("inc_hour_cnt", 4'(cnt_p), 4'd1);
    chk("no_tick_set", 4'(cnt_t), 4'd0);

    // SET_MIN, bouncy inc
    hold(3'b001, 6);
    repeat (8) step();
    chk("mode_min", {2'b0, mode}, 4'd2);
    cnt_p = 0;
    for (int i = 0; i < 20; i++) begin
      btn_inc = ((i % 6) < 3);
      step();
      cnt_p += int'(inc_min);
    end
    btn_inc = 1'b0;
    repeat (8) begin
      step();
      cnt_p += int'(inc_min);
    end
    chk("bounce_cnt", 4'(cnt_p), 4'd0);
    btn_inc = 1'b1;
    repeat (6) begin
      step();
      cnt_p += int'(inc_min);
    end
    btn_inc = 1'b0;
    repeat (10) begin
      step();
      cnt_p += int'(inc_min);
    end
    chk("hold_cnt", 4'(cnt_p), 4'd1);

    // SET_SEC, clr and inc together
    hold(3'b001, 6);
    repeat (8) step();
    chk("mode_sec", {2'b0, mode}, 4'd3);
    cnt_p = 0; cnt_t = 0; c_clr = -1; c_tick = -1;
    {btn_clr, btn_inc, btn_mode} = 3'b110;
    for (int i = 0; i < 40; i++) begin
      if (i == 6) {btn_clr, btn_inc, btn_mode} = 3'b000;
      step();
      cnt_p += int'(inc_sec);
      cnt_t += int'(clr_time);
      if (clr_time && c_clr < 0) c_clr = t;
      if (tick_1hz && c_clr >= 0 && c_tick < 0) c_tick = t;
    end
    chk("clr_cnt", 4'(cnt_t), 4'd1);
    chk("clr_no_inc", 4'(cnt_p), 4'd0);
    chk("clr_mode", {2'b0, mode}, 4'd0);
    chk("clr_to_tick", 4'(c_tick - c_clr), 4'd10);

    // reset mid-second with mode press in flight
    for (int i = 0; i < 12 && ((t - anchor) % HZ) != 6; i++)
      step();
    btn_mode = 1'b1;
    step();
    chk("div_at_7", {3'b0, blink}, 4'd0);
    repeat (3) step();
    do_reset();
    btn_mode = 1'b0;
    repeat (20) step();
    chk("no_step_after_rst", {2'b0, mode}, 4'd0);

    // button already held at reset release
    btn_mode = 1'b1;
    do_reset();
    repeat (7) step();
    btn_mode = 1'b0;
    chk("held_c7", {2'b0, mode}, 4'd0);
    step();
    chk("held_c8", {2'b0, mode}, 4'd1);
    repeat (6) step();

    // random buttons
    for (int k = 0; k < 250; k++) begin
      logic [2:0] b;
      b = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) b[2] = 1'b0;
      {btn_clr, btn_inc, btn_mode} = b;
      repeat ($urandom_range(1, 9)) step();
    end
    {btn_clr, btn_inc, btn_mode} = 3'b000;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
